// File: rtl/pbs_pkg.sv
// Shared types and default sizes for the battle-simulator turn logic.
package pbs_pkg;

  localparam int HP_W_DEF        = 4;
  localparam int SPD_W_DEF       = 8;
  localparam int MOVE_W_DEF      = 2;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int CNT_W           = 8;

  // Turn sequencing states.
  typedef enum logic [3:0] {
    ST_COLLECT,
    ST_ORDER,
    ST_REQ1,
    ST_CHK1,
    ST_REQ2,
    ST_CHK2,
    ST_DONE,
    ST_VICTORY,
    ST_LOSS
  } state_e;

  // Trainer encoding, shared with the damage datapath's active_trainer/target.
  typedef enum logic {
    PLAYER = 1'b0,
    AI     = 1'b1
  } trainer_e;

endpackage

// File: rtl/pbs_turn_order.sv
// Decides who attacks first: faster side wins, ties alternate via tie_pref.
module pbs_turn_order
  import pbs_pkg::*;
#(
  parameter int SPD_W = SPD_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe_i,
  input  logic [SPD_W-1:0] p_speed_i,
  input  logic [SPD_W-1:0] ai_speed_i,
  output trainer_e         first_o
);

  logic tie_pref_q, tie_pref_d;
  logic tie;

  // Speed compare; on a tie the preference register picks the side.
  always_comb begin
    tie        = (p_speed_i == ai_speed_i);
    tie_pref_d = tie_pref_q;
    if (p_speed_i > ai_speed_i)      first_o = PLAYER;
    else if (ai_speed_i > p_speed_i) first_o = AI;
    else                             first_o = tie_pref_q ? AI : PLAYER;
    if (strobe_i && tie) tie_pref_d = ~tie_pref_q;
  end

  // Tie preference only moves when a tie is resolved in ORDER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tie_pref_q <= 1'b0;
    else          tie_pref_q <= tie_pref_d;
  end

endmodule

// File: rtl/pbs_turn_sched.sv
// Turn scheduler: collects both moves, orders attacks by speed, drives the
// damage request handshake and checks HP after each attack.
module pbs_turn_sched
  import pbs_pkg::*;
#(
  parameter int HP_W        = HP_W_DEF,
  parameter int SPD_W       = SPD_W_DEF,
  parameter int MOVE_W      = MOVE_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_move_valid,
  output logic              p_move_ready,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              ai_move_valid,
  output logic              ai_move_ready,
  input  logic [MOVE_W-1:0] ai_move,
  input  logic [SPD_W-1:0]  p_speed,
  input  logic [SPD_W-1:0]  ai_speed,
  input  logic [HP_W-1:0]   p_hp,
  input  logic [HP_W-1:0]   ai_hp,
  output logic              dmg_req,
  output logic              dmg_attacker,
  output logic [MOVE_W-1:0] dmg_move,
  input  logic              dmg_ack,
  output logic              turn_done,
  output logic [CNT_W-1:0]  turn_count,
  output logic              victory,
  output logic              loss,
  output logic              timeout_err
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                p_held_q, p_held_d, ai_held_q, ai_held_d;
  logic [MOVE_W-1:0]   p_move_q, p_move_d, ai_move_q, ai_move_d;
  trainer_e            att_q, att_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
  trainer_e            first;

  pbs_turn_order #(.SPD_W(SPD_W)) u_order (
    .clk       (clk),
    .reset_n   (reset_n),
    .strobe_i  (state_q == ST_ORDER),
    .p_speed_i (p_speed),
    .ai_speed_i(ai_speed),
    .first_o   (first)
  );

  // Outputs decode straight from registers so an async reset clears them at once.
  always_comb begin
    p_move_ready  = (state_q == ST_COLLECT) && !p_held_q;
    ai_move_ready = (state_q == ST_COLLECT) && !ai_held_q;
    dmg_req       = (state_q == ST_REQ1) || (state_q == ST_REQ2);
    dmg_attacker  = att_q;
    dmg_move      = (att_q == AI) ? ai_move_q : p_move_q;
    turn_done     = (state_q == ST_DONE);
    turn_count    = cnt_q;
    victory       = (state_q == ST_VICTORY);
    loss          = (state_q == ST_LOSS);
    timeout_err   = tmo_q;
  end

  // Next-state logic; the wait counter is zero outside a request so each
  // request starts its own timeout window.
  always_comb begin
    state_d   = state_q;
    p_held_d  = p_held_q;
    ai_held_d = ai_held_q;
    p_move_d  = p_move_q;
    ai_move_d = ai_move_q;
    att_d     = att_q;
    wait_d    = '0;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (p_move_valid && p_move_ready) begin
          p_held_d = 1'b1;
          p_move_d = p_move;
        end
        if (ai_move_valid && ai_move_ready) begin
          ai_held_d = 1'b1;
          ai_move_d = ai_move;
        end
        if (p_held_d && ai_held_d) state_d = ST_ORDER;
      end
      ST_ORDER: begin
        att_d   = first;
        state_d = ST_REQ1;
      end
      ST_REQ1, ST_REQ2: begin
        wait_d = wait_q + WAIT_W'(1);
        if (dmg_ack) begin
          state_d = (state_q == ST_REQ1) ? ST_CHK1 : ST_CHK2;
        end else if (wait_q == WAIT_LAST) begin
          // Abandon the turn: no turn_done, moves discarded.
          tmo_d     = 1'b1;
          state_d   = ST_COLLECT;
          p_held_d  = 1'b0;
          ai_held_d = 1'b0;
          p_move_d  = '0;
          ai_move_d = '0;
        end
      end
      ST_CHK1, ST_CHK2: begin
        // AI fainting is checked first so a double KO counts as a win.
        if (ai_hp == '0)     state_d = ST_VICTORY;
        else if (p_hp == '0) state_d = ST_LOSS;
        else if (state_q == ST_CHK1) begin
          att_d   = (att_q == PLAYER) ? AI : PLAYER;
          state_d = ST_REQ2;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        p_held_d  = 1'b0;
        ai_held_d = 1'b0;
        p_move_d  = '0;
        ai_move_d = '0;
        state_d   = ST_COLLECT;
      end
      default: ; // VICTORY / LOSS hold until reset
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_COLLECT;
      p_held_q  <= 1'b0;
      ai_held_q <= 1'b0;
      p_move_q  <= '0;
      ai_move_q <= '0;
      att_q     <= PLAYER;
      wait_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_held_q  <= p_held_d;
      ai_held_q <= ai_held_d;
      p_move_q  <= p_move_d;
      ai_move_q <= ai_move_d;
      att_q     <= att_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pbs_turn_sched.sv
// Bench for pbs_turn_sched: vector table, hand sequences, randomized turns.
module tb_pbs_turn_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       p_move_valid = 0, ai_move_valid = 0;
  logic       p_move_ready, ai_move_ready;
  logic [1:0] p_move = 0, ai_move = 0;
  logic [7:0] p_speed = 0, ai_speed = 0;
  logic [3:0] p_hp = 15, ai_hp = 15;
  logic       dmg_req, dmg_attacker, dmg_ack = 0;
  logic [1:0] dmg_move;
  logic       turn_done, victory, loss, timeout_err;
  logic [7:0] turn_count;

  int checks = 0, failures = 0, td_cnt = 0;

  always #5 clk = ~clk;

  pbs_turn_sched dut (
    .clk(clk), .reset_n(reset_n),
    .p_move_valid(p_move_valid), .p_move_ready(p_move_ready), .p_move(p_move),
    .ai_move_valid(ai_move_valid), .ai_move_ready(ai_move_ready), .ai_move(ai_move),
    .p_speed(p_speed), .ai_speed(ai_speed), .p_hp(p_hp), .ai_hp(ai_hp),
    .dmg_req(dmg_req), .dmg_attacker(dmg_attacker), .dmg_move(dmg_move), .dmg_ack(dmg_ack),
    .turn_done(turn_done), .turn_count(turn_count),
    .victory(victory), .loss(loss), .timeout_err(timeout_err)
  );

  always @(negedge clk) if (turn_done === 1'b1) td_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req"}, dmg_req, 0);
    chk({tag, " attacker"}, dmg_attacker, 0);
    chk({tag, " move"}, dmg_move, 0);
    chk({tag, " turn_done"}, turn_done, 0);
    chk({tag, " count"}, turn_count, 0);
    chk({tag, " victory"}, victory, 0);
    chk({tag, " loss"}, loss, 0);
    chk({tag, " timeout"}, timeout_err, 0);
  endtask

  // Called at a negedge; leaves reset released at a negedge in COLLECT.
  task automatic do_reset;
    reset_n = 0; p_move_valid = 0; ai_move_valid = 0; dmg_ack = 0;
    p_hp = 15; ai_hp = 15;
    repeat (2) cyc;
    reset_n = 1;
  endtask

  // One full turn from COLLECT. eout: 0 done, 1 victory, 2 loss.
  task automatic run_turn(input logic [7:0] ps, input logic [7:0] as,
                          input logic [1:0] pm, input logic [1:0] am,
                          input int d1, input int d2,
                          input logic [3:0] h1p, input logic [3:0] h1a,
                          input logic [3:0] h2p, input logic [3:0] h2a,
                          input logic ef, input int eout, input int enreq,
                          input int ecnt, input string tag);
    logic att;
    logic [1:0] mv;
    p_speed = ps; ai_speed = as; p_hp = 15; ai_hp = 15;
    chk({tag, " p_ready idle"}, p_move_ready, 1);
    chk({tag, " ai_ready idle"}, ai_move_ready, 1);
    p_move = pm; ai_move = am; p_move_valid = 1; ai_move_valid = 1;
    cyc;
    p_move_valid = 0; ai_move_valid = 0;
    chk({tag, " ready after capture"}, {p_move_ready, ai_move_ready}, 0);
    chk({tag, " req in order"}, dmg_req, 0);
    cyc;
    for (int r = 1; r <= enreq; r++) begin
      att = (r == 1) ? ef : ~ef;
      mv  = att ? am : pm;
      chk({tag, " req up"}, dmg_req, 1);
      chk({tag, " attacker"}, dmg_attacker, att);
      chk({tag, " move"}, dmg_move, mv);
      repeat ((r == 1) ? d1 : d2) cyc;
      chk({tag, " req held"}, dmg_req, 1);
      chk({tag, " ready in req"}, {p_move_ready, ai_move_ready}, 0);
      dmg_ack = 1;
      cyc;
      dmg_ack = 0;
      if (r == 1) begin p_hp = h1p; ai_hp = h1a; end
      else        begin p_hp = h2p; ai_hp = h2a; end
      chk({tag, " req down in chk"}, dmg_req, 0);
      cyc;
    end
    if (eout == 0) begin
      chk({tag, " turn_done"}, turn_done, 1);
      cyc;
      chk({tag, " turn_done pulse"}, turn_done, 0);
      chk({tag, " count"}, turn_count, ecnt);
      chk({tag, " ready next"}, {p_move_ready, ai_move_ready}, 2'b11);
    end else begin
      chk({tag, " victory"}, victory, (eout == 1));
      chk({tag, " loss"}, loss, (eout == 2));
      chk({tag, " req terminal"}, dmg_req, 0);
      chk({tag, " no turn_done"}, turn_done, 0);
      p_move_valid = 1; ai_move_valid = 1;
      repeat (3) begin
        cyc;
        chk({tag, " ready terminal"}, {p_move_ready, ai_move_ready}, 0);
        chk({tag, " req stays low"}, dmg_req, 0);
      end
      p_move_valid = 0; ai_move_valid = 0;
      chk({tag, " flag held"}, {victory, loss}, (eout == 1) ? 2'b10 : 2'b01);
      chk({tag, " count kept"}, turn_count, ecnt);
    end
  endtask

  typedef struct {
    bit rst;
    logic [7:0] ps, as;
    logic [1:0] pm, am;
    int d1, d2;
    logic [3:0] h1p, h1a, h2p, h2a;
    logic ef;
    int eout, enreq, ecnt;
  } vec_t;

  vec_t tbl[8];

  // Reference model state for the randomized section.
  logic tie_m;
  int   cnt_m;

  function automatic logic [3:0] rnd_hp();
    return ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    tbl[0] = '{0, 50, 30, 1, 2, 3, 3, 9, 9, 8, 8, 0, 0, 2, 1};
    tbl[1] = '{0, 40, 40, 2, 3, 0, 1, 7, 7, 7, 7, 0, 0, 2, 2};
    tbl[2] = '{0, 40, 40, 3, 1, 1, 0, 6, 6, 5, 5, 1, 0, 2, 3};
    tbl[3] = '{0, 10, 60, 0, 3, 2, 2, 4, 4, 3, 3, 1, 0, 2, 4};
    tbl[4] = '{0, 70, 20, 2, 1, 0, 0, 5, 0, 5, 5, 0, 1, 1, 4};
    tbl[5] = '{1, 10, 90, 1, 2, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    tbl[6] = '{1, 90, 10, 3, 2, 0, 2, 6, 6, 0, 6, 0, 2, 2, 0};
    tbl[7] = '{1, 10, 90, 1, 1, 0, 0, 0, 7, 1, 1, 1, 2, 1, 0};

    cyc;
    chk_reset_vals("in reset");
    do_reset;
    chk("ready after reset", {p_move_ready, ai_move_ready}, 2'b11);
    chk_reset_vals("after reset");

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset;
      run_turn(tbl[i].ps, tbl[i].as, tbl[i].pm, tbl[i].am, tbl[i].d1, tbl[i].d2,
               tbl[i].h1p, tbl[i].h1a, tbl[i].h2p, tbl[i].h2a, tbl[i].ef,
               tbl[i].eout, tbl[i].enreq, tbl[i].ecnt, $sformatf("vec%0d", i));
    end

    // Async reset while the second request is pending.
    do_reset;
    p_speed = 50; ai_speed = 30; p_move = 1; ai_move = 2;
    p_move_valid = 1; ai_move_valid = 1;
    cyc; p_move_valid = 0; ai_move_valid = 0;
    cyc; dmg_ack = 1;
    cyc; dmg_ack = 0;
    cyc;
    chk("rst req2 up", dmg_req, 1);
    chk("rst req2 attacker", dmg_attacker, 1);
    #2 reset_n = 0;
    #1 chk("async req drop", dmg_req, 0);
    chk_reset_vals("async reset");
    cyc; cyc;
    reset_n = 1;
    chk("ready after async", {p_move_ready, ai_move_ready}, 2'b11);
    run_turn(40, 40, 3, 0, 0, 0, 9, 9, 9, 9, 0, 0, 2, 1, "post-reset tie");

    // Staggered capture, then an ack that never comes.
    p_speed = 50; ai_speed = 30; p_move = 2; ai_move = 1;
    p_move_valid = 1;
    cyc; p_move_valid = 0;
    chk("stagger ready", {p_move_ready, ai_move_ready}, 2'b01);
    cyc;
    chk("stagger waiting", dmg_req, 0);
    ai_move_valid = 1;
    cyc; ai_move_valid = 0;
    chk("stagger order", dmg_req, 0);
    cyc;
    chk("tmo req up", dmg_req, 1);
    begin
      int td0;
      td0 = td_cnt;
      repeat (254) cyc;
      chk("tmo req before limit", dmg_req, 1);
      chk("tmo flag before limit", timeout_err, 0);
      cyc;
      chk("tmo req dropped", dmg_req, 0);
      chk("tmo flag", timeout_err, 1);
      chk("tmo ready", {p_move_ready, ai_move_ready}, 2'b11);
      chk("tmo no turn_done", td_cnt - td0, 0);
      chk("tmo count", turn_count, 1);
    end
    dmg_ack = 1;
    cyc; dmg_ack = 0;
    chk("stray ack ignored", {dmg_req, p_move_ready, ai_move_ready}, 3'b011);
    run_turn(50, 30, 1, 3, 1, 1, 8, 8, 8, 8, 0, 0, 2, 2, "after tmo");
    chk("tmo sticky", timeout_err, 1);

    // Saturation of the turn counter.
    do_reset;
    for (int i = 0; i < 257; i++)
      run_turn(30, 50, 2'(i), 2'(i + 1), 0, 0, 15, 15, 15, 15, 1, 0, 2,
               (i + 1 > 255) ? 255 : i + 1, "sat");

    // Randomized turns against the rule-level model.
    do_reset;
    tie_m = 0; cnt_m = 0;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] ps, as;
      logic [1:0] pm, am;
      logic [3:0] h1p, h1a, h2p, h2a;
      logic ef;
      int eout, enreq;
      ps = 8'($urandom_range(0, 3) * 20); as = 8'($urandom_range(0, 3) * 20);
      pm = 2'($urandom); am = 2'($urandom);
      h1p = rnd_hp(); h1a = rnd_hp(); h2p = rnd_hp(); h2a = rnd_hp();
      if (ps > as)      ef = 0;
      else if (as > ps) ef = 1;
      else begin ef = tie_m; tie_m = ~tie_m; end
      if (h1a == 0)      begin eout = 1; enreq = 1; end
      else if (h1p == 0) begin eout = 2; enreq = 1; end
      else if (h2a == 0) begin eout = 1; enreq = 2; end
      else if (h2p == 0) begin eout = 2; enreq = 2; end
      else begin eout = 0; enreq = 2; if (cnt_m < 255) cnt_m++; end
      run_turn(ps, as, pm, am, $urandom_range(0, 4), $urandom_range(0, 4),
               h1p, h1a, h2p, h2a, ef, eout, enreq, cnt_m, $sformatf("rnd%0d", n));
      if (eout != 0) begin
        do_reset;
        tie_m = 0; cnt_m = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
